// File: rtl/shell_cmd_parser.sv
// shell_cmd_parser: incremental parser for a line-oriented UART command shell.
// A command line is "<letter> [hex] [hex] CR". It is parsed one byte at a time,
// so the design needs no line buffer. A good line is presented as a pending
// command. A bad line is swallowed up to its CR and then reported with a single
// o_Err pulse.
// Optional feature: define SHELL_ECHO_EN to echo the received bytes back on
// o_TX_DV/o_TX_Byte. Without that macro the TX outputs are tied to zero.
`timescale 1ns/1ps
module shell_cmd_parser #(
  parameter int ARG_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_RX_DV,
  input  logic [7:0]       i_RX_Byte,
  output logic             o_Cmd_Valid,
  input  logic             i_Cmd_Ready,
  output logic [7:0]       o_Cmd_Op,
  output logic [ARG_W-1:0] o_Cmd_Arg0,
  output logic [ARG_W-1:0] o_Cmd_Arg1,
  output logic [1:0]       o_Cmd_Argc,
  output logic             o_Err,
  output logic             o_TX_DV,
  output logic [7:0]       o_TX_Byte,
  output logic [2:0]       dbg_state
);

  localparam int NDIG = ARG_W / 4;
  localparam int DW   = $clog2(NDIG + 1);
  localparam logic [DW-1:0] DIG_MAX = DW'(NDIG);
  localparam logic [DW-1:0] DIG_ONE = DW'(1);
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OP      = 3'd1,
    S_SEP     = 3'd2,
    S_ARG     = 3'd3,
    S_DISCARD = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [ARG_W-1:0] arg0_q, arg0_d, arg1_q, arg1_d;
  logic [1:0]       argc_q, argc_d;
  logic [DW-1:0]    ndig_q, ndig_d;
  logic             err_q, err_d;

  logic             rx_take;
  logic             is_hex;
  logic             is_alpha;
  logic [3:0]       nib;

  // LF is invisible to the parser in every state.
  assign rx_take = i_RX_DV && (i_RX_Byte != CH_LF);

  // Byte classification: hex digit with its nibble value, and ASCII letter.
  always_comb begin
    is_hex   = 1'b0;
    nib      = 4'h0;
    is_alpha = 1'b0;
    if (i_RX_Byte >= 8'h30 && i_RX_Byte <= 8'h39) begin
      is_hex = 1'b1;
      nib    = i_RX_Byte[3:0];
    end else if ((i_RX_Byte >= 8'h61 && i_RX_Byte <= 8'h66) ||
                 (i_RX_Byte >= 8'h41 && i_RX_Byte <= 8'h46)) begin
      is_hex = 1'b1;
      nib    = i_RX_Byte[3:0] + 4'd9;
    end
    if ((i_RX_Byte >= 8'h61 && i_RX_Byte <= 8'h7A) ||
        (i_RX_Byte >= 8'h41 && i_RX_Byte <= 8'h5A)) begin
      is_alpha = 1'b1;
    end
  end

  // Next-state and field update logic of the line parser.
  // Command handshake: o_Cmd_Valid stays high while a command is pending. The
  // op/args/argc fields do not change during that time. The command is taken
  // on any rising edge where o_Cmd_Valid and i_Cmd_Ready are both high.
  // i_Cmd_Ready may already be high before o_Cmd_Valid rises.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg0_d  = arg0_q;
    arg1_d  = arg1_q;
    argc_d  = argc_q;
    ndig_d  = ndig_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_take) begin
          if (i_RX_Byte == CH_SP || i_RX_Byte == CH_CR) begin
            state_d = S_IDLE;
          end else if (is_alpha) begin
            op_d    = i_RX_Byte | 8'h20;
            state_d = S_OP;
          end else begin
            state_d = S_DISCARD;
          end
        end
      end
      S_OP, S_SEP: begin
        if (rx_take) begin
          if (i_RX_Byte == CH_SP) begin
            state_d = S_SEP;
          end else if (is_hex && argc_q != 2'd2) begin
            if (argc_q == 2'd0) arg0_d = {{(ARG_W-4){1'b0}}, nib};
            else                arg1_d = {{(ARG_W-4){1'b0}}, nib};
            ndig_d  = DIG_ONE;
            state_d = S_ARG;
          end else if (i_RX_Byte == CH_CR) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_DISCARD;
          end
        end
      end
      S_ARG: begin
        if (rx_take) begin
          if (is_hex) begin
            if (ndig_q == DIG_MAX) begin
              state_d = S_DISCARD;
            end else begin
              if (argc_q == 2'd0) arg0_d = {arg0_q[ARG_W-5:0], nib};
              else                arg1_d = {arg1_q[ARG_W-5:0], nib};
              ndig_d = ndig_q + DIG_ONE;
            end
          end else if (i_RX_Byte == CH_SP) begin
            argc_d  = argc_q + 2'd1;
            state_d = S_SEP;
          end else if (i_RX_Byte == CH_CR) begin
            argc_d  = argc_q + 2'd1;
            state_d = S_HOLD;
          end else begin
            state_d = S_DISCARD;
          end
        end
      end
      S_DISCARD: begin
        if (rx_take && i_RX_Byte == CH_CR) begin
          err_d   = 1'b1;
          op_d    = 8'h00;
          arg0_d  = '0;
          arg1_d  = '0;
          argc_d  = 2'd0;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (i_Cmd_Ready) begin
          op_d    = 8'h00;
          arg0_d  = '0;
          arg1_d  = '0;
          argc_d  = 2'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Parser state and command fields. Reset abandons any partial line silently.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= 8'h00;
      arg0_q  <= '0;
      arg1_q  <= '0;
      argc_q  <= 2'd0;
      ndig_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg0_q  <= arg0_d;
      arg1_q  <= arg1_d;
      argc_q  <= argc_d;
      ndig_q  <= ndig_d;
      err_q   <= err_d;
    end
  end

  assign o_Cmd_Valid = (state_q == S_HOLD);
  assign o_Cmd_Op    = op_q;
  assign o_Cmd_Arg0  = arg0_q;
  assign o_Cmd_Arg1  = arg1_q;
  assign o_Cmd_Argc  = argc_q;
  assign o_Err       = err_q;
  assign dbg_state   = state_q;

`ifdef SHELL_ECHO_EN
  logic       tx_dv_q;
  logic [7:0] tx_byte_q;
  logic       lf_pend_q;

  // Echo each byte taken outside HOLD one cycle later; a CR is followed by an LF.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      lf_pend_q <= 1'b0;
    end else if (rx_take && state_q != S_HOLD) begin
      tx_dv_q   <= 1'b1;
      tx_byte_q <= i_RX_Byte;
      lf_pend_q <= (i_RX_Byte == CH_CR);
    end else if (lf_pend_q) begin
      tx_dv_q   <= 1'b1;
      tx_byte_q <= CH_LF;
      lf_pend_q <= 1'b0;
    end else begin
      tx_dv_q   <= 1'b0;
    end
  end

  assign o_TX_DV   = tx_dv_q;
  assign o_TX_Byte = tx_byte_q;
`else
  assign o_TX_DV   = 1'b0;
  assign o_TX_Byte = 8'h00;
`endif

endmodule

// File: tb/tb_shell_cmd_parser.sv
// tb_shell_cmd_parser: directed and randomized checks for shell_cmd_parser.
// Honours SHELL_ECHO_EN the same way the design does.
`timescale 1ns/1ps
module tb_shell_cmd_parser;

  localparam int ARG_W = 16;
  localparam int NDIG  = ARG_W / 4;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;

  // ---------------- clock / reset ----------------
  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             i_RX_DV = 1'b0;
  logic [7:0]       i_RX_Byte = 8'h00;
  logic             i_Cmd_Ready = 1'b0;
  logic             o_Cmd_Valid;
  logic [7:0]       o_Cmd_Op;
  logic [ARG_W-1:0] o_Cmd_Arg0;
  logic [ARG_W-1:0] o_Cmd_Arg1;
  logic [1:0]       o_Cmd_Argc;
  logic             o_Err;
  logic             o_TX_DV;
  logic [7:0]       o_TX_Byte;
  logic [2:0]       dbg_state;

  always #5 CLK = ~CLK;

  shell_cmd_parser #(.ARG_W(ARG_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_RX_DV     (i_RX_DV),
    .i_RX_Byte   (i_RX_Byte),
    .o_Cmd_Valid (o_Cmd_Valid),
    .i_Cmd_Ready (i_Cmd_Ready),
    .o_Cmd_Op    (o_Cmd_Op),
    .o_Cmd_Arg0  (o_Cmd_Arg0),
    .o_Cmd_Arg1  (o_Cmd_Arg1),
    .o_Cmd_Argc  (o_Cmd_Argc),
    .o_Err       (o_Err),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;
  bit rdy_rand = 1'b0;
  bit rdy_man  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready is driven in mid-cycle: either held by the directed tests or randomized.
  always @(posedge CLK) begin
    #2;
    i_Cmd_Ready = rdy_rand ? ($urandom_range(0, 3) == 0) : rdy_man;
  end

  // ---------------- reference model (whole-line evaluation) ----------------
  logic [7:0]       line_q[$];
  bit               holding = 1'b0;
  bit               exp_err = 1'b0;
  bit               exp_tx_dv = 1'b0;
  logic [7:0]       exp_tx_byte = 8'h00;
  bit               lf_pend = 1'b0;
  logic [7:0]       m_op = 8'h00;
  logic [ARG_W-1:0] m_a0 = '0;
  logic [ARG_W-1:0] m_a1 = '0;
  logic [1:0]       m_argc = 2'd0;
  logic [7:0]       tx_log[$];

  function automatic bit tb_is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    if (c <= "9") return int'(c) - 48;
    if (c >= "a") return int'(c) - 97 + 10;
    return int'(c) - 65 + 10;
  endfunction

  // The line goes through this task when its CR arrives.
  // res=0 means nothing to report, res=1 means a command, res=2 means an error.
  task automatic eval_line(output int res);
    int i;
    int n;
    int argc;
    int len;
    longint val;
    logic [7:0] c;
    logic [ARG_W-1:0] a[2];
    n = line_q.size();
    i = 0;
    res = 0;
    argc = 0;
    a[0] = '0;
    a[1] = '0;
    while (i < n && line_q[i] == SP) i++;
    if (i == n) return;
    c = line_q[i];
    if (!((c >= "a" && c <= "z") || (c >= "A" && c <= "Z"))) begin
      res = 2;
      return;
    end
    i++;
    while (i < n) begin
      if (line_q[i] == SP) begin
        i++;
        continue;
      end
      len = 0;
      val = 0;
      while (i < n && line_q[i] != SP) begin
        if (!tb_is_hex(line_q[i])) begin
          res = 2;
          return;
        end
        val = val * 16 + longint'(hex_val(line_q[i]));
        len++;
        i++;
      end
      if (len > NDIG || argc == 2) begin
        res = 2;
        return;
      end
      a[argc] = val[ARG_W-1:0];
      argc++;
    end
    m_op   = c | 8'h20;
    m_a0   = a[0];
    m_a1   = a[1];
    m_argc = argc[1:0];
    res    = 1;
  endtask

  always @(posedge CLK) begin
    bit was_hold;
    int res;
    if (RST) begin
      line_q.delete();
      holding     = 1'b0;
      exp_err     = 1'b0;
      exp_tx_dv   = 1'b0;
      exp_tx_byte = 8'h00;
      lf_pend     = 1'b0;
    end else begin
      was_hold = holding;
      exp_err  = 1'b0;
      if (i_RX_DV && i_RX_Byte != LF && !was_hold) begin
        exp_tx_dv   = 1'b1;
        exp_tx_byte = i_RX_Byte;
        lf_pend     = (i_RX_Byte == CR);
        if (i_RX_Byte == CR) begin
          eval_line(res);
          line_q.delete();
          if (res == 1) holding = 1'b1;
          else if (res == 2) exp_err = 1'b1;
        end else begin
          line_q.push_back(i_RX_Byte);
        end
      end else if (lf_pend) begin
        exp_tx_dv   = 1'b1;
        exp_tx_byte = LF;
        lf_pend     = 1'b0;
      end else begin
        exp_tx_dv = 1'b0;
      end
      if (was_hold && i_Cmd_Ready) holding = 1'b0;
    end
  end

  // ---------------- scoreboard compare, every cycle on the falling edge ----------------
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("cmd_valid", o_Cmd_Valid, holding);
      check("err", o_Err, exp_err);
      if (holding) begin
        check("cmd_op", o_Cmd_Op, m_op);
        check("cmd_arg0", o_Cmd_Arg0, m_a0);
        check("cmd_arg1", o_Cmd_Arg1, m_a1);
        check("cmd_argc", o_Cmd_Argc, m_argc);
      end
`ifdef SHELL_ECHO_EN
      check("tx_dv", o_TX_DV, exp_tx_dv);
      if (exp_tx_dv) check("tx_byte", o_TX_Byte, exp_tx_byte);
`else
      check("tx_dv_off", o_TX_DV, 1'b0);
      check("tx_byte_off", o_TX_Byte, 8'h00);
`endif
      if (o_TX_DV === 1'b1) tx_log.push_back(o_TX_Byte);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge CLK);
    #1;
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    @(posedge CLK);
    #1;
    i_RX_DV   = 1'b0;
    repeat (gap) @(posedge CLK);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Raise ready until the pending command is gone, bounded.
  task automatic release_cmd();
    int n;
    rdy_man = 1'b1;
    n = 0;
    while (o_Cmd_Valid === 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("release_timeout", o_Cmd_Valid, 1'b0);
    rdy_man = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] lb[$];
    string hx;
    int nargs;
    int len;
    int kind;
    int rst_at;
    hx = "0123456789abcdefABCDEF";

    repeat (3) @(posedge CLK);
    #1;
    // Reset values
    check("rst_valid", o_Cmd_Valid, 1'b0);
    check("rst_err", o_Err, 1'b0);
    check("rst_op", o_Cmd_Op, 8'h00);
    check("rst_arg0", o_Cmd_Arg0, 16'h0000);
    check("rst_arg1", o_Cmd_Arg1, 16'h0000);
    check("rst_argc", o_Cmd_Argc, 2'd0);
    check("rst_tx_dv", o_TX_DV, 1'b0);
    RST    = 1'b0;
    cmp_en = 1'b1;
    step();
    // A byte strobed while reset is high is ignored
    RST = 1'b1;
    i_RX_DV = 1'b1;
    i_RX_Byte = "g";
    step();
    i_RX_DV = 1'b0;
    RST = 1'b0;
    send_byte(CR, 0);
    check("dv_in_reset_valid", o_Cmd_Valid, 1'b0);

    // "g" CR: valid one cycle after the CR strobe
    send_str("g");
    check("g_pre_valid", o_Cmd_Valid, 1'b0);
    send_byte(CR, 0);
    check("g_valid", o_Cmd_Valid, 1'b1);
    check("g_op", o_Cmd_Op, 8'h67);
    check("g_argc", o_Cmd_Argc, 2'd0);
    check("g_arg0", o_Cmd_Arg0, 16'h0000);
    check("g_arg1", o_Cmd_Arg1, 16'h0000);
    release_cmd();

    // "w 0011 1111" CR, ready held low for 10 cycles
    send_str("w 0011 1111");
    send_byte(CR, 0);
    for (int i = 0; i < 10; i++) begin
      check("w_valid", o_Cmd_Valid, 1'b1);
      check("w_op", o_Cmd_Op, 8'h77);
      check("w_arg0", o_Cmd_Arg0, 16'h0011);
      check("w_arg1", o_Cmd_Arg1, 16'h1111);
      check("w_argc", o_Cmd_Argc, 2'd2);
      step();
    end
    release_cmd();

    // "r  ABcd" CR with ready already high
    rdy_man = 1'b1;
    send_str("r  ABcd");
    send_byte(CR, 0);
    check("r_valid", o_Cmd_Valid, 1'b1);
    check("r_op", o_Cmd_Op, 8'h72);
    check("r_arg0", o_Cmd_Arg0, 16'hABCD);
    check("r_argc", o_Cmd_Argc, 2'd1);
    step();
    check("r_taken", o_Cmd_Valid, 1'b0);
    rdy_man = 1'b0;

    // "r 12345" CR: argument too long -> error pulse, then "g" still works
    send_str("r 12345");
    send_byte(CR, 0);
    check("long_err", o_Err, 1'b1);
    check("long_valid", o_Cmd_Valid, 1'b0);
    step();
    check("long_err_once", o_Err, 1'b0);
    send_str("g");
    send_byte(CR, 0);
    check("after_err_valid", o_Cmd_Valid, 1'b1);
    check("after_err_op", o_Cmd_Op, 8'h67);
    release_cmd();

    // "g " then reset then CR: line abandoned silently
    send_str("g ");
    RST = 1'b1;
    step();
    RST = 1'b0;
    send_byte(CR, 0);
    check("rst_mid_valid", o_Cmd_Valid, 1'b0);
    check("rst_mid_err", o_Err, 1'b0);

    // Bytes arriving while a command is pending are dropped
    send_str("g");
    send_byte(CR, 0);
    send_str("x1");
    send_byte(CR, 0);
    check("hold_drop_valid", o_Cmd_Valid, 1'b1);
    check("hold_drop_op", o_Cmd_Op, 8'h67);
    check("hold_drop_err", o_Err, 1'b0);
    release_cmd();

    // Echo of "g" CR
    repeat (3) step();
    tx_log.delete();
    send_str("g");
    send_byte(CR, 0);
    repeat (3) step();
`ifdef SHELL_ECHO_EN
    check("echo_count", tx_log.size(), 3);
    if (tx_log.size() == 3) begin
      check("echo_0", tx_log[0], 8'h67);
      check("echo_1", tx_log[1], 8'h0D);
      check("echo_2", tx_log[2], 8'h0A);
    end
`else
    check("echo_none", tx_log.size(), 0);
`endif
    release_cmd();

    // Randomized lines against the model
    rdy_rand = 1'b1;
    for (int ln = 0; ln < 200; ln++) begin
      lb.delete();
      kind = $urandom_range(0, 9);
      repeat ($urandom_range(0, 1)) lb.push_back(SP);
      if (kind == 0) lb.push_back("#");
      else lb.push_back(8'(($urandom_range(0, 1) ? 8'h61 : 8'h41) + 8'($urandom_range(0, 25))));
      nargs = (kind == 3) ? 3 : $urandom_range(0, 2);
      if (kind == 4) lb.delete();
      else begin
        for (int a = 0; a < nargs; a++) begin
          if (!(a == 0 && $urandom_range(0, 7) == 0)) repeat ($urandom_range(1, 2)) lb.push_back(SP);
          len = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(1, 4);
          for (int d = 0; d < len; d++) lb.push_back(hx[$urandom_range(0, 21)]);
        end
        if ($urandom_range(0, 3) == 0) lb.push_back(SP);
        if (kind == 1) lb.insert($urandom_range(0, lb.size()), "!");
        if (kind == 2) lb.insert($urandom_range(0, lb.size()), LF);
      end
      lb.push_back(CR);
      rst_at = ($urandom_range(0, 29) == 0) ? $urandom_range(0, lb.size() - 1) : -1;
      for (int b = 0; b < lb.size(); b++) begin
        if (b == rst_at) begin
          RST = 1'b1;
          step();
          RST = 1'b0;
        end
        send_byte(lb[b], $urandom_range(0, 2));
      end
    end
    rdy_rand = 1'b0;
    rdy_man  = 1'b1;
    repeat (10) step();

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Overall time bound
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation exceeded time limit, got %0t expected under 2000000", $time);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shell_cmd_parser.md
SHELL_CMD_PARSER -- requirements
Module: shell_cmd_parser

Interface
REQ-001 SHALL have parameter ARG_W, default 16: width of each hex argument; must be a multiple of 4.
REQ-002 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_RX_DV  input  1  one-cycle strobe: i_RX_Byte valid, from UART_RX.
REQ-005 SHALL have port i_RX_Byte  input  8  received ASCII byte.
REQ-006 SHALL have port o_Cmd_Valid  output  1  parsed command held pending.
REQ-007 SHALL have port i_Cmd_Ready  input  1  consumer accepts the pending command.
REQ-008 SHALL have port o_Cmd_Op  output  8  opcode character, lower-case ASCII.
REQ-009 SHALL have port o_Cmd_Arg0  output  ARG_W  first hex argument, zero if absent.
REQ-010 SHALL have port o_Cmd_Arg1  output  ARG_W  second hex argument, zero if absent.
REQ-011 SHALL have port o_Cmd_Argc  output  2  number of arguments parsed, 0-2.
REQ-012 SHALL have port o_Err  output  1  one-cycle strobe on a rejected line.
REQ-013 SHALL have port o_TX_DV  output  1  one-cycle strobe: o_TX_Byte valid, to UART_TX.
REQ-014 SHALL have port o_TX_Byte  output  8  echo byte.

Function
REQ-015 SHALL parse incrementally, one byte per i_RX_DV, with no line buffer; states IDLE, OP, SEP, ARG, DISCARD, HOLD.
REQ-016 IDLE: space ignored; letter a-z/A-Z -> o_Cmd_Op (folded to lower case), go OP; CR -> stay IDLE, no command; any other byte -> DISCARD.
REQ-017 OP/SEP: space -> SEP; hex digit (0-9,a-f,A-F) when Argc<2 -> start new argument with that nibble, go ARG; CR -> HOLD; else -> DISCARD.
REQ-018 ARG: hex digit -> arg <= {arg[ARG_W-5:0], nibble}; space -> Argc+1, go SEP; CR -> Argc+1, go HOLD; else -> DISCARD.
REQ-019 More than ARG_W/4 digits in one argument, or a third argument, SHALL go DISCARD.
REQ-020 DISCARD: ignore bytes until CR; on CR pulse o_Err one cycle, clear op/args/Argc, go IDLE.
REQ-021 HOLD: o_Cmd_Valid=1 with op/args/Argc stable; leave to IDLE, clearing fields, on the cycle i_Cmd_Ready=1 (ready may be high before valid).
REQ-022 o_Cmd_Valid SHALL rise the cycle after the CR strobe (latency 1).
REQ-023 Bytes arriving in HOLD SHALL be dropped without echo; no error.
REQ-024 LF (0x0A) SHALL be ignored in every state.
REQ-025 i_RX_DV with RST high SHALL be ignored.

Reset
REQ-026 RST SHALL force IDLE; o_Cmd_Valid, o_Err, o_TX_DV=0; o_Cmd_Op, o_Cmd_Arg0, o_Cmd_Arg1, o_TX_Byte=0; o_Cmd_Argc=0.
REQ-027 RST mid-line or in HOLD SHALL abandon the command with no o_Err pulse.

Configuration
REQ-028 With SHELL_ECHO_EN defined, every accepted (non-HOLD) byte SHALL be echoed on o_TX_Byte/o_TX_DV the cycle after i_RX_DV; CR echoes as CR, then LF on the next cycle.
REQ-029 Without SHELL_ECHO_EN, o_TX_DV and o_TX_Byte SHALL be constant 0.

Verification
REQ-030 "g",CR -> o_Cmd_Valid 1 cycle after CR, Op=0x67, Argc=0, Arg0=Arg1=0.
REQ-031 "w 0011 1111",CR, ready low 10 cycles -> Op=0x77, Arg0=0x0011, Arg1=0x1111, Argc=2, fields stable until ready.
REQ-032 "r  ABcd",CR -> Op=0x72, Arg0=0xABCD, Argc=1.
REQ-033 "r 12345",CR -> no o_Cmd_Valid; o_Err pulse 1 cycle after CR; next "g",CR parsed normally.
REQ-034 "g " then RST then CR -> idle, no valid, no error; bytes in HOLD dropped.
REQ-035 SHELL_ECHO_EN: "g",CR -> TX bytes 0x67, 0x0D, 0x0A; without macro -> no o_TX_DV.
